// File: rtl/fetch_queue_if.sv
// Fetch/decode handshake bundle for fetch_queue.
// The master modport is the fetch+decode side and the slave modport is the queue.
// Member names keep the queue-relative _i/_o suffixes so that both sides read the same.
interface fetch_queue_if;
   logic        flush_i;
   logic [1:0]  push_cnt_i;
   logic [31:0] pc_i;
   logic [31:0] inst0_i;
   logic [31:0] inst1_i;
   logic        ready_o;
   logic [1:0]  pop_cnt_i;
   logic [1:0]  avail_o;
   logic [31:0] inst0_o;
   logic [31:0] inst1_o;
   logic [31:0] pc0_o;
   logic [31:0] pc1_o;

   modport master (
      output flush_i, push_cnt_i, pc_i, inst0_i, inst1_i, pop_cnt_i,
      input  ready_o, avail_o, inst0_o, inst1_o, pc0_o, pc1_o
   );

   modport slave (
      input  flush_i, push_cnt_i, pc_i, inst0_i, inst1_i, pop_cnt_i,
      output ready_o, avail_o, inst0_o, inst1_o, pc0_o, pc1_o
   );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: 2-wide in / 2-wide out instruction queue between fetch and decode.
// Each entry holds {inst, pc} in a circular buffer addressed by head/tail pointers.
// An occupancy count is kept alongside the pointers.
// Optional feature macro FETCH_QUEUE_BYPASS_EN: while the queue is empty, the fetch
// inputs are forwarded straight to the outputs. Only the entries that decode does not
// consume in that same cycle are stored.
// DEPTH must be a power of two and at least 4; the pointers rely on natural wrap.
module fetch_queue #(
   parameter int DEPTH = 8
) (
   input  logic         clk_i,
   input  logic         rst_n_i,
   fetch_queue_if.slave bus
);
   localparam int          AW  = $clog2(DEPTH);
   localparam int          CW  = AW + 1;
   localparam logic [31:0] NOP = 32'h00000013;

   // Queue state
   logic [AW-1:0] head_q, head_d;
   logic [AW-1:0] tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;

   // Entry storage; no reset needed because count_q decides what is valid
   logic [31:0] inst_mem [DEPTH];
   logic [31:0] pc_mem   [DEPTH];

   // Per-cycle control
   logic          ready;
   logic [1:0]    push_req;
   logic [1:0]    push_acc;
   logic [1:0]    pop_req;
   logic [1:0]    pop_eff;
   logic [1:0]    avail_reg;
   logic [1:0]    avail;
   logic          bypass_act;

   // Incoming pair, as slot-indexed arrays for the generate loops
   logic [31:0]   in_inst [2];
   logic [31:0]   in_pc   [2];
   logic [1:0]    wr_en;
   logic [AW-1:0] wr_idx  [2];

   // Clamp requests, derive acceptance and visible head count
   always_comb begin
      push_req  = (bus.push_cnt_i == 2'd3) ? 2'd2 : bus.push_cnt_i;
      pop_req   = (bus.pop_cnt_i  == 2'd3) ? 2'd2 : bus.pop_cnt_i;
      // ready depends on registered count only, so pop_cnt_i never reaches it
      ready     = (count_q <= CW'(DEPTH - 2));
      push_acc  = ready ? push_req : 2'd0;
      avail_reg = (count_q >= CW'(2)) ? 2'd2 : count_q[1:0];
`ifdef FETCH_QUEUE_BYPASS_EN
      // Reset gates the forward path so outputs are idle while rst_n_i is low
      bypass_act = rst_n_i && (count_q == '0) && !bus.flush_i;
      if (bus.flush_i) begin
         avail = 2'd0;
      end else if (bypass_act) begin
         avail = push_acc;
      end else begin
         avail = avail_reg;
      end
`else
      bypass_act = 1'b0;
      avail      = avail_reg;
`endif
      pop_eff = (pop_req > avail) ? avail : pop_req;
   end

   assign in_inst[0] = bus.inst0_i;
   assign in_inst[1] = bus.inst1_i;
   assign in_pc[0]   = bus.pc_i;
   assign in_pc[1]   = bus.pc_i + 32'd4;

   assign bus.ready_o = ready;
   assign bus.avail_o = avail;

   // Per-slot write selection and output steering
   for (genvar gi = 0; gi < 2; gi++) begin : g_slot
      logic [AW-1:0] rd_idx;
      logic [31:0]   src_inst;
      logic [31:0]   src_pc;
      logic          slot_valid;

      // Slot gi of an accepted push lands at tail+gi.
      // When bypassing, entries already consumed by the same-cycle pop are not stored.
      assign wr_idx[gi] = tail_q + AW'(gi);
      assign wr_en[gi]  = !bus.flush_i && (push_acc > 2'(gi)) &&
                          (!bypass_act || (pop_eff <= 2'(gi)));

      assign rd_idx     = head_q + AW'(gi);
      assign src_inst   = bypass_act ? in_inst[gi] : inst_mem[rd_idx];
      assign src_pc     = bypass_act ? in_pc[gi]   : pc_mem[rd_idx];
      assign slot_valid = (avail > 2'(gi));

      if (gi == 0) begin : g_out0
         assign bus.inst0_o = slot_valid ? src_inst : NOP;
         assign bus.pc0_o   = slot_valid ? src_pc   : 32'd0;
      end else begin : g_out1
         assign bus.inst1_o = slot_valid ? src_inst : NOP;
         assign bus.pc1_o   = slot_valid ? src_pc   : 32'd0;
      end
   end

   // Pointer and count update; flush wins over push and pop
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (bus.flush_i) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         // Pop first consumes from head. In bypass mode head==tail, so the
         // unconsumed bypass entries are written at tail+pop_eff = new head.
         head_d  = head_q + AW'(pop_eff);
         tail_d  = tail_q + AW'(push_acc);
         count_d = count_q + CW'(push_acc) - CW'(pop_eff);
      end
   end

   // State registers with asynchronous clear
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Entry storage write port (up to two entries per cycle)
   always_ff @(posedge clk_i) begin
      for (int j = 0; j < 2; j++) begin
         if (wr_en[j]) begin
            inst_mem[wr_idx[j]] <= in_inst[j];
            pc_mem[wr_idx[j]]   <= in_pc[j];
         end
      end
   end
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue.
// The reference model is a queue of {inst, pc} entries, updated per cycle from the
// push, pop and flush rules. Directed scenarios come first, then randomized traffic.
module tb_fetch_queue;
   localparam int          DEPTH = 8;
   localparam logic [31:0] NOP   = 32'h00000013;
   localparam logic [63:0] IDLE  = {NOP, 32'd0};

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   logic [63:0] model [$];
   bit          track_pc;
   logic [31:0] next_pc;

   fetch_queue_if bus ();

   fetch_queue #(.DEPTH(DEPTH)) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One cycle: drive at the falling edge, check the combinational view,
   // advance the model, then wait for the next falling edge.
   task automatic step(input bit fl, input int pn, input int pp,
                       input logic [31:0] pc, input logic [31:0] i0, input logic [31:0] i1);
      logic [63:0] offer [2];
      logic [63:0] vis   [2];
      logic [31:0] used_pc;
      int nvis, acc, pe, pr, qr, sz;
      bit byp, rdy;
      bus.flush_i    = fl;
      bus.push_cnt_i = 2'(pn);
      bus.pop_cnt_i  = 2'(pp);
      bus.pc_i       = pc;
      bus.inst0_i    = i0;
      bus.inst1_i    = i1;
      #1;
      offer[0] = {i0, pc};
      offer[1] = {i1, pc + 32'd4};
      sz  = model.size();
      rdy = (sz <= DEPTH - 2);
      pr  = (pn > 2) ? 2 : pn;
      qr  = (pp > 2) ? 2 : pp;
      acc = rdy ? pr : 0;
      byp = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
      byp = (sz == 0) && !fl;
`endif
      if (byp) begin
         nvis   = acc;
         vis[0] = offer[0];
         vis[1] = offer[1];
      end else begin
         nvis   = (sz > 2) ? 2 : sz;
         vis[0] = (sz > 0) ? model[0] : IDLE;
         vis[1] = (sz > 1) ? model[1] : IDLE;
      end
`ifdef FETCH_QUEUE_BYPASS_EN
      if (fl) nvis = 0;
`endif
      check("ready", 64'(bus.ready_o), 64'(rdy));
      check("avail", 64'(bus.avail_o), 64'(nvis));
      check("slot0", {bus.inst0_o, bus.pc0_o}, (nvis > 0) ? vis[0] : IDLE);
      check("slot1", {bus.inst1_o, bus.pc1_o}, (nvis > 1) ? vis[1] : IDLE);
      pe = (qr > nvis) ? nvis : qr;
      if (fl) pe = 0;
      // Consumed PCs, taken from the DUT outputs, must follow fetch order
      if (track_pc) begin
         for (int k = 0; k < pe; k++) begin
            used_pc = (k == 0) ? bus.pc0_o : bus.pc1_o;
            check("pc_seq", 64'(used_pc), 64'(next_pc));
            next_pc = next_pc + 32'd4;
         end
      end
      if (fl) begin
         model.delete();
      end else if (byp) begin
         for (int k = pe; k < acc; k++) model.push_back(offer[k]);
      end else begin
         for (int k = 0; k < acc; k++) model.push_back(offer[k]);
         for (int k = 0; k < pe; k++) void'(model.pop_front());
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle_step();
      step(1'b0, 0, 0, 32'd0, 32'd0, 32'd0);
   endtask

   initial begin
      logic [31:0] fp;
      checks   = 0;
      errors   = 0;
      track_pc = 1'b0;
      next_pc  = 32'd0;
      rst_n    = 1'b0;
      bus.flush_i    = 1'b0;
      bus.push_cnt_i = 2'd2;
      bus.pop_cnt_i  = 2'd0;
      bus.pc_i       = 32'h40;
      bus.inst0_i    = 32'h1;
      bus.inst1_i    = 32'h2;

      // Reset state, with a push offered while reset is held
      #2;
      check("rst_avail", 64'(bus.avail_o), 64'd0);
      check("rst_ready", 64'(bus.ready_o), 64'd1);
      check("rst_slot0", {bus.inst0_o, bus.pc0_o}, IDLE);
      check("rst_slot1", {bus.inst1_o, bus.pc1_o}, IDLE);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Basic 2-wide push, visible the next cycle
      step(1'b0, 2, 0, 32'h100, 32'hA, 32'hB);
      #1;
      check("b_avail", 64'(bus.avail_o), 64'd2);
      check("b_inst0", 64'(bus.inst0_o), 64'hA);
      check("b_pc0",   64'(bus.pc0_o),   64'h100);
      check("b_inst1", 64'(bus.inst1_o), 64'hB);
      check("b_pc1",   64'(bus.pc1_o),   64'h104);
      step(1'b0, 0, 2, 32'd0, 32'd0, 32'd0);
      idle_step();

      // Fill to DEPTH, then a further push is dropped
      for (int i = 0; i < 4; i++)
         step(1'b0, 2, 0, 32'h1000 + 32'(i * 8), 32'hC0 + 32'(i * 2), 32'hC1 + 32'(i * 2));
      #1;
      check("full_ready", 64'(bus.ready_o), 64'd0);
      step(1'b0, 2, 0, 32'h9000, 32'hDEAD, 32'hBEEF);
      for (int i = 0; i < 4; i++) step(1'b0, 0, 2, 32'd0, 32'd0, 32'd0);
      idle_step();

      // Over-pop with one entry, combined with a 2-wide push
      step(1'b1, 0, 0, 32'd0, 32'd0, 32'd0);
      step(1'b0, 1, 0, 32'h200, 32'h21, 32'h0);
      step(1'b0, 2, 3, 32'h204, 32'h22, 32'h23);
      #1;
      check("op_avail", 64'(bus.avail_o), 64'd2);
      check("op_pc0",   64'(bus.pc0_o),   64'h204);
      check("op_pc1",   64'(bus.pc1_o),   64'h208);
      step(1'b0, 0, 2, 32'd0, 32'd0, 32'd0);

      // Move head to DEPTH-1 with 3 entries, then stream across the wrap
      step(1'b1, 0, 0, 32'd0, 32'd0, 32'd0);
      fp       = 32'h4000;
      next_pc  = fp;
      track_pc = 1'b1;
      step(1'b0, 2, 0, fp, fp ^ 32'h5A5A, fp ^ 32'h5A5E); fp += 8;
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 2, 2, fp, fp ^ 32'h5A5A, fp ^ 32'h5A5E); fp += 8;
      end
      step(1'b0, 1, 1, fp, fp ^ 32'h5A5A, 32'd0); fp += 4;
      step(1'b0, 1, 0, fp, fp ^ 32'h5A5A, 32'd0); fp += 4;
      for (int i = 0; i < 20; i++) begin
         step(1'b0, 2, 2, fp, fp ^ 32'h5A5A, fp ^ 32'h5A5E); fp += 8;
      end
      track_pc = 1'b0;

      // Flush with 5 entries, competing with push and pop
      step(1'b0, 2, 0, fp, 32'h77, 32'h78);
      step(1'b1, 2, 2, 32'h8000, 32'h99, 32'h9A);
      #1;
      check("fl_avail", 64'(bus.avail_o), 64'd0);
      check("fl_slot0", {bus.inst0_o, bus.pc0_o}, IDLE);
      check("fl_slot1", {bus.inst1_o, bus.pc1_o}, IDLE);
      idle_step();

`ifdef FETCH_QUEUE_BYPASS_EN
      // Empty queue, push 2 and pop 1 in the same cycle
      step(1'b0, 2, 1, 32'h300, 32'h31, 32'h32);
      #1;
      check("bp_avail", 64'(bus.avail_o), 64'd1);
      check("bp_inst0", 64'(bus.inst0_o), 64'h32);
      check("bp_pc0",   64'(bus.pc0_o),   64'h304);
      step(1'b0, 0, 2, 32'd0, 32'd0, 32'd0);
`endif

      // Randomized traffic
      for (int i = 0; i < 300; i++) begin
         step(($urandom_range(0, 19) == 0), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              $urandom & ~32'h3, $urandom, $urandom);
      end

      // Asynchronous reset in the middle of operation
      step(1'b0, 2, 0, 32'h500, 32'h51, 32'h52);
      step(1'b0, 2, 0, 32'h508, 32'h53, 32'h54);
      #2;
      rst_n = 1'b0;
      #1;
      check("mr_avail", 64'(bus.avail_o), 64'd0);
      check("mr_ready", 64'(bus.ready_o), 64'd1);
      check("mr_slot0", {bus.inst0_o, bus.pc0_o}, IDLE);
      check("mr_slot1", {bus.inst1_o, bus.pc1_o}, IDLE);
      model.delete();
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b0, 1, 0, 32'h600, 32'h61, 32'h0);
      idle_step();
      step(1'b0, 0, 1, 32'd0, 32'd0, 32'd0);
      idle_step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
